// File: rtl/snake_move_controller.sv
// Snake move sequencer: move tick, direction latch, next-head computation,
// wall/self/food detection and a single shift pulse per move into the body register.
module snake_move_controller #(
  parameter int unsigned  W        = 8,
  parameter int unsigned  MAX_LEN  = 16,
  parameter int unsigned  INIT_LEN = 3,
  parameter logic [W-1:0] INIT_XY  = 8'h88,
  parameter int unsigned  TICK_DIV = 12500000,
  parameter bit           WRAP     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           dir_in,
  input  logic                 dir_valid,
  input  logic [W-1:0]         food_xy,
  input  logic                 food_valid,
  input  logic [W*MAX_LEN-1:0] body,
  output logic                 shift_en,
  output logic [W-1:0]         head_next,
  output logic [4:0]           length,
  output logic                 ate,
  output logic [7:0]           score,
  output logic                 game_over,
  output logic                 running
);

  localparam int unsigned   HW       = W / 2;
  localparam int unsigned   CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [4:0]    LEN_INIT = 5'(INIT_LEN);
  localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP, S_DEAD} state_t;
  typedef enum logic [1:0] {D_UP = 2'b00, D_RIGHT = 2'b01, D_DOWN = 2'b10, D_LEFT = 2'b11} dir_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  dir_t          dir_q, dir_d, pend_q, pend_d, ref_dir;
  logic [W-1:0]  head_q, head_d;
  logic [4:0]    len_q, len_d;
  logic [7:0]    score_q, score_d;
  logic          shift_q, shift_d, ate_q, ate_d;

  logic [HW-1:0] hx, hy, nx_x, nx_y;
  logic [W-1:0]  nx;
  logic          wall, eat, self_hit;
  int unsigned   lim;

  // The move taken in STEP uses the pending direction, which is committed in the same cycle.
  always_comb begin
    hx   = head_q[W-1:HW];
    hy   = head_q[HW-1:0];
    nx_x = hx;
    nx_y = hy;
    wall = 1'b0;
    unique case (pend_q)
      D_UP:    begin nx_y = hy - HW'(1); wall = (hy == '0); end
      D_RIGHT: begin nx_x = hx + HW'(1); wall = (hx == '1); end
      D_DOWN:  begin nx_y = hy + HW'(1); wall = (hy == '1); end
      D_LEFT:  begin nx_x = hx - HW'(1); wall = (hx == '0); end
    endcase
    if (WRAP) wall = 1'b0;
    nx = {nx_x, nx_y};
  end

  // The tail slot vacates on a plain move, so it only blocks when the snake grows.
  always_comb begin
    eat      = food_valid && (nx == food_xy);
    lim      = eat ? 32'(len_q) : 32'(len_q) - 32'd1;
    self_hit = 1'b0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if ((i < lim) && (body[W*(MAX_LEN-i)-1 -: W] == nx)) self_hit = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    head_d  = head_q;
    len_d   = len_q;
    score_d = score_q;
    shift_d = 1'b0;
    ate_d   = 1'b0;
    ref_dir = dir_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_STEP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STEP: begin
        cnt_d   = cnt_q + CW'(1);
        dir_d   = pend_q;
        ref_dir = pend_q;
        if (wall || self_hit) begin
          state_d = S_DEAD;
        end else begin
          state_d = S_RUN;
          shift_d = 1'b1;
          head_d  = nx;
          ate_d   = eat;
          if (eat) begin
            if (len_q != LEN_MAX) len_d = len_q + 5'd1;
            if (score_q != 8'hFF) score_d = score_q + 8'd1;
          end
        end
      end
      S_DEAD: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          head_d  = INIT_XY;
          len_d   = LEN_INIT;
          score_d = '0;
          dir_d   = D_RIGHT;
          pend_d  = D_RIGHT;
          ref_dir = D_RIGHT;
        end
      end
    endcase
    if (dir_valid && (dir_in != (ref_dir ^ 2'b10))) pend_d = dir_t'(dir_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= D_RIGHT;
      pend_q  <= D_RIGHT;
      head_q  <= INIT_XY;
      len_q   <= LEN_INIT;
      score_q <= '0;
      shift_q <= 1'b0;
      ate_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      head_q  <= head_d;
      len_q   <= len_d;
      score_q <= score_d;
      shift_q <= shift_d;
      ate_q   <= ate_d;
    end
  end

  assign shift_en  = shift_q;
  assign head_next = head_q;
  assign length    = len_q;
  assign ate       = ate_q;
  assign score     = score_q;
  assign game_over = (state_q == S_DEAD);
  assign running   = (state_q == S_RUN) || (state_q == S_STEP);

endmodule

// File: tb/tb_snake_move_controller.sv
// Two controllers (wall and wrap variants) share random stimulus; a coordinate-level
// game model predicts every move/death event, which a negedge monitor compares.
module tb_snake_move_controller;
  localparam int         W   = 8;
  localparam int         ML  = 8;
  localparam int         IL  = 3;
  localparam logic [7:0] IXY = 8'h88;
  localparam int         TD  = 4;

  logic            clk = 1'b0;
  logic            rst, start, dir_valid, food_valid;
  logic [1:0]      dir_in;
  logic [W-1:0]    food_xy;
  logic [W*ML-1:0] body_r   [2];
  logic            shift_w  [2];
  logic [W-1:0]    head_w   [2];
  logic [4:0]      len_w    [2];
  logic            ate_w    [2];
  logic [7:0]      score_w  [2];
  logic            go_w     [2];
  logic            run_w    [2];

  always #5 clk = ~clk;

  snake_move_controller #(.W(W), .MAX_LEN(ML), .INIT_LEN(IL), .INIT_XY(IXY), .TICK_DIV(TD), .WRAP(1'b0))
  dut_wall (
    .clk(clk), .reset(rst), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
    .food_xy(food_xy), .food_valid(food_valid), .body(body_r[0]),
    .shift_en(shift_w[0]), .head_next(head_w[0]), .length(len_w[0]), .ate(ate_w[0]),
    .score(score_w[0]), .game_over(go_w[0]), .running(run_w[0])
  );

  snake_move_controller #(.W(W), .MAX_LEN(ML), .INIT_LEN(IL), .INIT_XY(IXY), .TICK_DIV(TD), .WRAP(1'b1))
  dut_wrap (
    .clk(clk), .reset(rst), .start(start), .dir_in(dir_in), .dir_valid(dir_valid),
    .food_xy(food_xy), .food_valid(food_valid), .body(body_r[1]),
    .shift_en(shift_w[1]), .head_next(head_w[1]), .length(len_w[1]), .ate(ate_w[1]),
    .score(score_w[1]), .game_over(go_w[1]), .running(run_w[1])
  );

  typedef struct {
    int         kind;   // 0 move, 1 death
    int         cyc;
    logic [7:0] head;
    int         len;
    int         score;
    bit         ate;
  } ev_t;

  ev_t        q0[$];
  ev_t        q1[$];
  int         mode   [2] = '{0, 0};  // 0 idle, 1 playing, 2 dead
  int         p      [2] = '{0, 0};  // clock edges since the game started
  int         dirm   [2] = '{1, 1};
  int         pend   [2] = '{1, 1};
  int         lenm   [2] = '{IL, IL};
  int         scorem [2] = '{0, 0};
  logic [7:0] snake  [2][ML];
  bit         restarted [2];
  bit         go_prev   [2] = '{1'b0, 1'b0};
  int         cyc = 0;
  bit         rst_seen = 1'b0;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [7:0] init_seg(int i);
    int x;
    x = (int'(IXY / 16) - i + 16 * ML) % 16;
    return 8'((x * 16) + int'(IXY % 16));
  endfunction

  function automatic logic [W*ML-1:0] init_body();
    logic [W*ML-1:0] b;
    b = '0;
    for (int i = 0; i < ML; i++) b[W*(ML-i)-1 -: W] = init_seg(i);
    return b;
  endfunction

  function automatic void model_reset(int k);
    p[k]      = 0;
    dirm[k]   = 1;
    pend[k]   = 1;
    lenm[k]   = IL;
    scorem[k] = 0;
    for (int i = 0; i < ML; i++) snake[k][i] = init_seg(i);
  endfunction

  function automatic void dir_req(int k, int refd);
    if (dir_valid && (int'(dir_in) != (refd ^ 2))) pend[k] = int'(dir_in);
  endfunction

  function automatic void push_ev(int k, ev_t e);
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  function automatic void do_move(int k);
    int x, y, lim;
    bit wall, eat, hit;
    logic [7:0] nx;
    ev_t e;
    dirm[k] = pend[k];
    x = int'(snake[k][0] / 16);
    y = int'(snake[k][0] % 16);
    case (dirm[k])
      0:       y = y - 1;
      1:       x = x + 1;
      2:       y = y + 1;
      default: x = x - 1;
    endcase
    wall = 1'b0;
    if (x < 0 || x > 15 || y < 0 || y > 15) begin
      if (k == 1) begin
        x = (x + 16) % 16;
        y = (y + 16) % 16;
      end else begin
        wall = 1'b1;
      end
    end
    nx  = 8'(((x & 15) * 16) + (y & 15));
    eat = food_valid && (nx == food_xy);
    lim = eat ? lenm[k] : lenm[k] - 1;
    hit = 1'b0;
    for (int i = 0; i < lim; i++) if (snake[k][i] == nx) hit = 1'b1;
    e.cyc = cyc;
    if (wall || hit) begin
      mode[k] = 2;
      e.kind  = 1;
      e.head  = snake[k][0];
      e.ate   = 1'b0;
    end else begin
      for (int i = ML - 1; i > 0; i--) snake[k][i] = snake[k][i-1];
      snake[k][0] = nx;
      if (eat) begin
        if (lenm[k] < ML) lenm[k] = lenm[k] + 1;
        if (scorem[k] < 255) scorem[k] = scorem[k] + 1;
      end
      e.kind = 0;
      e.head = nx;
      e.ate  = eat;
    end
    e.len   = lenm[k];
    e.score = scorem[k];
    push_ev(k, e);
  endfunction

  function automatic logic [7:0] nxt_pred(int k);
    int x, y;
    x = int'(snake[k][0] / 16);
    y = int'(snake[k][0] % 16);
    case (pend[k])
      0:       y = y - 1;
      1:       x = x + 1;
      2:       y = y + 1;
      default: x = x - 1;
    endcase
    return 8'((((x + 16) % 16) * 16) + ((y + 16) % 16));
  endfunction

  function automatic bit step_next_any();
    bit r;
    r = 1'b0;
    for (int k = 0; k < 2; k++)
      if (mode[k] == 1 && (p[k] + 1) >= TD + 1 && ((p[k] + 1 - TD - 1) % TD) == 0) r = 1'b1;
    return r;
  endfunction

  // Reference model and the body shift register the controllers read back.
  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = rst;
    for (int k = 0; k < 2; k++) begin
      restarted[k] = 1'b0;
      if (rst) begin
        model_reset(k);
        mode[k] = 0;
        if (k == 0) q0.delete();
        else        q1.delete();
      end else begin
        case (mode[k])
          0: begin
            dir_req(k, dirm[k]);
            if (start) begin
              mode[k] = 1;
              p[k]    = 0;
            end
          end
          1: begin
            p[k] = p[k] + 1;
            if (p[k] >= TD + 1 && ((p[k] - TD - 1) % TD) == 0) do_move(k);
            else dir_req(k, dirm[k]);
          end
          default: begin
            if (start) begin
              model_reset(k);
              mode[k]      = 1;
              restarted[k] = 1'b1;
            end
            dir_req(k, dirm[k]);
          end
        endcase
      end
      if (rst || restarted[k]) body_r[k] <= init_body();
      else if (shift_w[k])     body_r[k] <= {head_w[k], body_r[k][W*ML-1:W]};
    end
  end

  function automatic void check_inst(int k);
    ev_t e;
    bit have, ev_now, rise;
    int akind;
    checks++;
    if (run_w[k] !== (mode[k] == 1) || go_w[k] !== (mode[k] == 2)) begin
      errors++;
      $display("FAIL status[%0d] cyc=%0d running=%b game_over=%b required running=%b game_over=%b",
               k, cyc, run_w[k], go_w[k], (mode[k] == 1), (mode[k] == 2));
    end
    if (rst_seen) begin
      checks++;
      if (shift_w[k] !== 1'b0 || ate_w[k] !== 1'b0 || head_w[k] !== IXY ||
          len_w[k] !== 5'(IL) || score_w[k] !== 8'd0) begin
        errors++;
        $display("FAIL reset_values[%0d] cyc=%0d shift_en=%b ate=%b head_next=%h length=%0d score=%0d required 0 0 %h %0d 0",
                 k, cyc, shift_w[k], ate_w[k], head_w[k], len_w[k], score_w[k], IXY, IL);
      end
    end
    have = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
    if (have) begin
      if (k == 0) e = q0[0];
      else        e = q1[0];
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event[%0d] cyc=%0d no output seen, required kind=%0d head_next=%h at cyc=%0d",
                 k, cyc, e.kind, e.head, e.cyc);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
    rise   = go_w[k] && !go_prev[k];
    ev_now = shift_w[k] || ate_w[k] || rise;
    if (ev_now) begin
      checks++;
      akind = shift_w[k] ? 0 : (rise ? 1 : 0);
      have  = (k == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (have) begin
        if (k == 0) e = q0[0];
        else        e = q1[0];
      end
      if (!have || e.cyc != cyc) begin
        errors++;
        $display("FAIL unexpected_event[%0d] cyc=%0d shift_en=%b ate=%b game_over=%b head_next=%h, required none",
                 k, cyc, shift_w[k], ate_w[k], go_w[k], head_w[k]);
      end else begin
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        if (akind != e.kind || shift_w[k] !== (e.kind == 0) || head_w[k] !== e.head ||
            int'(len_w[k]) != e.len || int'(score_w[k]) != e.score || ate_w[k] !== e.ate) begin
          errors++;
          $display("FAIL event[%0d] cyc=%0d got kind=%0d shift=%b head=%h len=%0d score=%0d ate=%b required kind=%0d head=%h len=%0d score=%0d ate=%b",
                   k, cyc, akind, shift_w[k], head_w[k], len_w[k], score_w[k], ate_w[k],
                   e.kind, e.head, e.len, e.score, e.ate);
        end
      end
    end
    go_prev[k] = go_w[k];
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) check_inst(k);
  end

  task automatic drive(input logic r, input logic st, input logic dv, input logic [1:0] d,
                       input logic fv, input logic [7:0] f);
    rst        = r;
    start      = st;
    dir_valid  = dv && !step_next_any();
    dir_in     = d;
    food_valid = fv;
    food_xy    = f;
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] f;
    int sel;
    rst = 1'b1; start = 1'b0; dir_valid = 1'b0; dir_in = 2'b00;
    food_valid = 1'b0; food_xy = 8'h00;
    @(negedge clk);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    // first move lands on food, then a reverse request and a turn up
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 8'h98);
    repeat (8) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 8'h98);
    drive(1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 8'h00);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00);
    repeat (12) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    // reset lands while the tick counter reads 2
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    repeat (2) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    // straight run right: wall variant dies at x=F, wrap variant wraps to x=0
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    repeat (40) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 8'h00);
    repeat (10) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    for (int n = 0; n < 20000; n++) begin
      sel = $urandom_range(0, 3);
      if (sel == 0)      f = nxt_pred(0);
      else if (sel == 1) f = nxt_pred(1);
      else               f = 8'($urandom);
      drive(($urandom_range(0, 3999) == 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0), f);
    end
    repeat (20) drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("FAIL pending_events got %0d outstanding, required 0", q0.size() + q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
